operand_fetch_stage: RTL

//  Decode/operand-fetch pipeline stage directly upstream of the 32x32 register file.

---
 rtl/operand_fetch_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives regfile read addresses, resolves operands with
// EX/MEM and MEM/WB forwarding, stalls on load-use, and registers the ID/EX entry.
module operand_fetch_stage #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned FWD_EN = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [31:0]       i_in_instr,
   input  logic [XLEN-1:0]   i_in_pc,
   output logic [4:0]        o_rs1_addr,
   output logic [4:0]        o_rs2_addr,
   input  logic [XLEN-1:0]   i_rs1_rdata,
   input  logic [XLEN-1:0]   i_rs2_rdata,
   input  logic              i_exmem_wen,
   input  logic [4:0]        i_exmem_rd,
   input  logic [XLEN-1:0]   i_exmem_data,
   input  logic              i_memwb_wen,
   input  logic [4:0]        i_memwb_rd,
   input  logic [XLEN-1:0]   i_memwb_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [XLEN-1:0]   o_out_pc,
   output logic [31:0]       o_out_instr,
   output logic [XLEN-1:0]   o_out_rs1_val,
   output logic [XLEN-1:0]   o_out_rs2_val,
   output logic [4:0]        o_out_rd,
   output logic              o_out_is_load,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;

   logic              r_valid;
   logic [XLEN-1:0]   r_pc;
   logic [31:0]       r_instr;
   logic [XLEN-1:0]   r_rs1_val;
   logic [XLEN-1:0]   r_rs2_val;
   logic [4:0]        r_rd;
   logic              r_is_load;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic [6:0]        w_opcode;
   logic [4:0]        w_rs1;
   logic [4:0]        w_rs2;
   logic              w_uses_rs1;
   logic              w_uses_rs2;
   logic              w_hz;
   logic              w_adv;
   logic              w_ready;
   logic              w_accept;
   logic              w_stall;
   logic [XLEN-1:0]   w_rs1_val;
   logic [XLEN-1:0]   w_rs2_val;

   // x0 is hardwired; younger in-flight results win over older ones and the regfile
   function automatic logic [XLEN-1:0] resolve(input logic [4:0] a, input logic [XLEN-1:0] rf,
                                               input logic ex_wen, input logic [4:0] ex_rd,
                                               input logic [XLEN-1:0] ex_data,
                                               input logic wb_wen, input logic [4:0] wb_rd,
                                               input logic [XLEN-1:0] wb_data);
      if (a == 5'd0)                                 return '0;
      if ((FWD_EN != 0) && ex_wen && (ex_rd == a))   return ex_data;
      if ((FWD_EN != 0) && wb_wen && (wb_rd == a))   return wb_data;
      return rf;
   endfunction

   assign w_opcode   = i_in_instr[6:0];
   assign w_rs1      = i_in_instr[19:15];
   assign w_rs2      = i_in_instr[24:20];
   assign w_uses_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) || (w_opcode == OPC_JAL));
   assign w_uses_rs2 = (w_opcode == OPC_BRANCH) || (w_opcode == OPC_STORE) || (w_opcode == OPC_OP);

   assign w_hz = r_valid && r_is_load && (r_rd != 5'd0) &&
                 ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));
   assign w_adv    = !r_valid || i_out_ready;
   assign w_ready  = w_adv && !w_hz && !i_flush;
   assign w_accept = i_in_valid && w_ready;
   assign w_stall  = i_in_valid && !w_ready && !i_flush;

   assign w_rs1_val = resolve(w_rs1, i_rs1_rdata, i_exmem_wen, i_exmem_rd, i_exmem_data,
                              i_memwb_wen, i_memwb_rd, i_memwb_data);
   assign w_rs2_val = resolve(w_rs2, i_rs2_rdata, i_exmem_wen, i_exmem_rd, i_exmem_data,
                              i_memwb_wen, i_memwb_rd, i_memwb_data);

   // ID/EX register: flush beats capture, capture beats bubble, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_instr     <= '0;
         r_rs1_val   <= '0;
         r_rs2_val   <= '0;
         r_rd        <= '0;
         r_is_load   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (i_flush) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_pc      <= i_in_pc;
            r_instr   <= i_in_instr;
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
            r_rd      <= i_in_instr[11:7];
            r_is_load <= (w_opcode == OPC_LOAD);
         end else if (w_adv) begin
            r_valid <= 1'b0;
         end
         if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign o_in_ready    = w_ready;
   assign o_rs1_addr    = w_rs1;
   assign o_rs2_addr    = w_rs2;
   assign o_out_valid   = r_valid;
   assign o_out_pc      = r_pc;
   assign o_out_instr   = r_instr;
   assign o_out_rs1_val = r_rs1_val;
   assign o_out_rs2_val = r_rs2_val;
   assign o_out_rd      = r_rd;
   assign o_out_is_load = r_is_load;
   assign o_stall_cnt   = r_stall_cnt;

endmodule
